// File: rtl/project1_alu_top.sv
// Registered signed ALU (add, sub, mul, div) with four active-low seven-segment
// digits showing either the operand magnitudes or the magnitudes of the two result halves.
module project1_alu_top #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           sel,
  output logic [2*WIDTH-1:0]   out,
  output logic [6:0]           seg_a_1,
  output logic [6:0]           seg_a_10,
  output logic [6:0]           seg_b_1,
  output logic [6:0]           seg_b_10,
  output logic                 overflow
);

  localparam int OW = 2 * WIDTH;
  localparam logic [WIDTH:0] TEN = (WIDTH+1)'(10);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  // Magnitude of a signed WIDTH-bit value; one extra bit so the most negative value fits.
  function automatic logic [WIDTH:0] mag_of(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    if (v[WIDTH-1]) begin
      mag_of = ~ext + ONE_EXT;
    end else begin
      mag_of = ext;
    end
  endfunction

  function automatic logic [3:0] ones_of(input logic [WIDTH:0] m);
    logic [WIDTH:0] r;
    r = m % TEN;
    ones_of = r[3:0];
  endfunction

  function automatic logic [3:0] tens_of(input logic [WIDTH:0] m);
    logic [WIDTH:0] r;
    r = (m / TEN) % TEN;
    tens_of = r[3:0];
  endfunction

  // Active-low segment pattern, bit6..bit0 = g..a; non-decimal codes blank the digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1111000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0010000;
      default: seg_encode = 7'b1111111;
    endcase
  endfunction

  logic [WIDTH:0]   a_ext_s;
  logic [WIDTH:0]   b_ext_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [OW-1:0]    a_wide_s;
  logic [OW-1:0]    b_wide_s;
  logic [OW-1:0]    prod_s;
  logic [WIDTH:0]   mag_a_s;
  logic [WIDTH:0]   mag_b_s;
  logic [WIDTH:0]   divisor_s;
  logic [WIDTH:0]   q_mag_s;
  logic [WIDTH:0]   r_mag_s;
  logic [WIDTH:0]   q_signed_s;
  logic [WIDTH:0]   r_signed_s;
  logic             div_zero_s;
  logic             div_ovf_s;
  logic [OW-1:0]    res_s;
  logic             ovf_s;

  // Arithmetic datapath: all four functions evaluated in parallel each cycle.
  always_comb begin
    a_ext_s  = {a[WIDTH-1], a};
    b_ext_s  = {b[WIDTH-1], b};
    sum_s    = a_ext_s + b_ext_s;
    diff_s   = a_ext_s - b_ext_s;
    a_wide_s = {{WIDTH{a[WIDTH-1]}}, a};
    b_wide_s = {{WIDTH{b[WIDTH-1]}}, b};
    prod_s   = a_wide_s * b_wide_s;

    // Divide on magnitudes then restore signs: truncation toward zero, remainder follows dividend.
    mag_a_s    = mag_of(a);
    mag_b_s    = mag_of(b);
    div_zero_s = (b == {WIDTH{1'b0}});
    div_ovf_s  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
    if (div_zero_s) begin
      divisor_s = ONE_EXT;
    end else begin
      divisor_s = mag_b_s;
    end
    q_mag_s = mag_a_s / divisor_s;
    r_mag_s = mag_a_s % divisor_s;
    if (a[WIDTH-1] ^ b[WIDTH-1]) begin
      q_signed_s = ~q_mag_s + ONE_EXT;
    end else begin
      q_signed_s = q_mag_s;
    end
    if (a[WIDTH-1]) begin
      r_signed_s = ~r_mag_s + ONE_EXT;
    end else begin
      r_signed_s = r_mag_s;
    end
  end

  // Function select and overflow rules.
  always_comb begin
    res_s = {OW{1'b0}};
    ovf_s = 1'b0;
    case (sel[1:0])
      2'b00: begin
        res_s = {{WIDTH{sum_s[WIDTH-1]}}, sum_s[WIDTH-1:0]};
        ovf_s = sum_s[WIDTH] ^ sum_s[WIDTH-1];
      end
      2'b01: begin
        res_s = {{WIDTH{diff_s[WIDTH-1]}}, diff_s[WIDTH-1:0]};
        ovf_s = diff_s[WIDTH] ^ diff_s[WIDTH-1];
      end
      2'b10: begin
        res_s = prod_s;
        ovf_s = 1'b0;
      end
      2'b11: begin
        if (div_zero_s) begin
          res_s = {{WIDTH{1'b1}}, a};
          ovf_s = 1'b1;
        end else if (div_ovf_s) begin
          res_s = {1'b1, {(OW-1){1'b0}}};
          ovf_s = 1'b1;
        end else begin
          res_s = {q_signed_s[WIDTH-1:0], r_signed_s[WIDTH-1:0]};
          ovf_s = 1'b0;
        end
      end
      default: begin
        res_s = {OW{1'b0}};
        ovf_s = 1'b0;
      end
    endcase
  end

  // Result and flag registers; reset wins over any computation.
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= {OW{1'b0}};
      overflow <= 1'b0;
    end else begin
      out      <= res_s;
      overflow <= ovf_s;
    end
  end

  logic [WIDTH-1:0] disp_a_s;
  logic [WIDTH-1:0] disp_b_s;
  logic [WIDTH:0]   disp_mag_a_s;
  logic [WIDTH:0]   disp_mag_b_s;

  // Display path: only sel[2] steers it, so a bad choose never reaches out/overflow.
  always_comb begin
    if (sel[2]) begin
      disp_a_s = out[OW-1:WIDTH];
      disp_b_s = out[WIDTH-1:0];
    end else begin
      disp_a_s = a;
      disp_b_s = b;
    end
    disp_mag_a_s = mag_of(disp_a_s);
    disp_mag_b_s = mag_of(disp_b_s);
    seg_a_1  = seg_encode(ones_of(disp_mag_a_s));
    seg_a_10 = seg_encode(tens_of(disp_mag_a_s));
    seg_b_1  = seg_encode(ones_of(disp_mag_b_s));
    seg_b_10 = seg_encode(tens_of(disp_mag_b_s));
  end

endmodule

// File: tb/tb_project1_alu_top.sv
// Scoreboard bench for project1_alu_top: expected results queued at drive time,
// popped and compared after the capturing edge, plus seven-segment checks.
module tb_project1_alu_top;

  localparam int W = 6;

  logic             clk;
  logic             rst;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [2:0]       sel;
  logic [2*W-1:0]   out;
  logic [6:0]       seg_a_1;
  logic [6:0]       seg_a_10;
  logic [6:0]       seg_b_1;
  logic [6:0]       seg_b_10;
  logic             overflow;

  int total;
  int bad;

  typedef struct {
    logic [11:0] o;
    logic        v;
  } exp_t;

  exp_t exp_q[$];

  project1_alu_top #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .out      (out),
    .seg_a_1  (seg_a_1),
    .seg_a_10 (seg_a_10),
    .seg_b_1  (seg_b_1),
    .seg_b_10 (seg_b_10),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [11:0] wrap_ext(input int t);
    int lo;
    lo = t & 63;
    if (lo >= 32) wrap_ext = 12'(lo | 32'hFC0);
    else wrap_ext = 12'(lo);
  endfunction

  function automatic exp_t model(input int ai, input int bi, input int f, input bit r);
    exp_t e;
    int t;
    e.o = 12'h000;
    e.v = 1'b0;
    if (!r) begin
      case (f)
        0: begin t = ai + bi; e.o = wrap_ext(t); e.v = (t > 31) || (t < -32); end
        1: begin t = ai - bi; e.o = wrap_ext(t); e.v = (t > 31) || (t < -32); end
        2: begin t = ai * bi; e.o = 12'(t & 32'hFFF); e.v = 1'b0; end
        default: begin
          if (bi == 0) begin
            e.o = 12'(32'hFC0 | (ai & 63)); e.v = 1'b1;
          end else if (ai == -32 && bi == -1) begin
            e.o = 12'h800; e.v = 1'b1;
          end else begin
            e.o = 12'((((ai / bi) & 63) << 6) | ((ai % bi) & 63)); e.v = 1'b0;
          end
        end
      endcase
    end
    return e;
  endfunction

  function automatic logic [6:0] seg7(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  function automatic int mag6(input int v);
    int s;
    s = v & 63;
    if (s >= 32) s = s - 64;
    return (s < 0) ? -s : s;
  endfunction

  // Drive one operation, queue its expectation, check after the capturing edge.
  task automatic run_op(input string tag, input int ai, input int bi, input int f,
                        input bit r, input bit ch, input bit ch_x);
    exp_t e;
    int da;
    int db;
    a   = ai[W-1:0];
    b   = bi[W-1:0];
    sel = {ch, f[1:0]};
    if (ch_x) sel[2] = 1'bx;
    rst = r;
    exp_q.push_back(model(ai, bi, f, r));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val({tag, ".out"}, 32'(out), 32'(e.o));
    check_val({tag, ".ovf"}, 32'(overflow), 32'(e.v));
    if (!ch_x) begin
      if (ch) begin
        da = mag6(int'(e.o[11:6]));
        db = mag6(int'(e.o[5:0]));
      end else begin
        da = mag6(ai);
        db = mag6(bi);
      end
      check_val({tag, ".sa10"}, 32'(seg_a_10), 32'(seg7(da / 10)));
      check_val({tag, ".sa1"},  32'(seg_a_1),  32'(seg7(da % 10)));
      check_val({tag, ".sb10"}, 32'(seg_b_10), 32'(seg7(db / 10)));
      check_val({tag, ".sb1"},  32'(seg_b_1),  32'(seg7(db % 10)));
    end
  endtask

  initial begin
    int edge_v [6];
    total = 0;
    bad   = 0;
    rst = 1'b1; a = '0; b = '0; sel = 3'b000;
    #1;

    run_op("reset",     17, -9, 2, 1'b1, 1'b0, 1'b0);
    run_op("add_ovf",   31,  1, 0, 1'b0, 1'b0, 1'b0);
    run_op("add_neg",   -5,  3, 0, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf",  -32,  1, 1, 1'b0, 1'b0, 1'b0);
    run_op("sub_ok",    10,-20, 1, 1'b0, 1'b1, 1'b0);
    run_op("mul_max",  -32,-32, 2, 1'b0, 1'b1, 1'b0);
    run_op("mul_min",   31,-32, 2, 1'b0, 1'b0, 1'b0);
    run_op("div_pos",   31,  5, 3, 1'b0, 1'b1, 1'b0);
    run_op("div_zero",   7,  0, 3, 1'b0, 1'b1, 1'b0);
    run_op("div_wrap", -32, -1, 3, 1'b0, 1'b1, 1'b0);
    run_op("div_neg",  -29,  4, 3, 1'b0, 1'b1, 1'b0);
    run_op("div_nz",   -20,  0, 3, 1'b0, 1'b0, 1'b0);
    run_op("rst_mid",    5,  3, 0, 1'b1, 1'b0, 1'b0);
    run_op("rst_rel",    5,  3, 0, 1'b0, 1'b0, 1'b0);
    run_op("disp_a",   -27, 14, 0, 1'b0, 1'b0, 1'b0);
    run_op("disp_x",   -27, 14, 1, 1'b0, 1'b0, 1'b1);
    run_op("disp_xm",  -32, 31, 2, 1'b0, 1'b0, 1'b1);

    edge_v = '{-32, -31, -1, 0, 1, 31};
    for (int i = 0; i < 240; i++) begin
      int ai;
      int bi;
      if (i % 3 == 0) begin
        ai = edge_v[$urandom_range(0, 5)];
        bi = edge_v[$urandom_range(0, 5)];
      end else begin
        ai = int'($urandom_range(0, 63)) - 32;
        bi = int'($urandom_range(0, 63)) - 32;
      end
      run_op("rand", ai, bi, int'($urandom_range(0, 3)),
             ($urandom_range(0, 19) == 0), bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
